// File: rtl/piso_tx_sequencer_if.sv
// Word handshake and shift-register drive bundle for piso_tx_sequencer.
// The master side is the word producer; the slave side is the sequencer,
// which also owns the strobes towards the external PISO shift register.
interface piso_tx_sequencer_if #(
  parameter int SIZE = 4
);
  logic [SIZE-1:0] data_in;
  logic            data_valid;
  logic            data_ready;
  logic            abort;
  logic [SIZE-1:0] piso_data;
  logic            piso_load;
  logic            piso_en;
  logic            busy;
  logic            done;

  modport master (
    output data_in, data_valid, abort,
    input  data_ready, piso_data, piso_load, piso_en, busy, done
  );

  modport slave (
    input  data_in, data_valid, abort,
    output data_ready, piso_data, piso_load, piso_en, busy, done
  );
endinterface

// File: rtl/piso_tx_sequencer.sv
// Sequencer for an external parallel-in/serial-out shift register.
// Accepts one SIZE-bit word per transaction, issues a one-cycle load strobe,
// then one shift-enable strobe every BIT_TICKS clocks until SIZE bits have
// been shifted, followed by a one-cycle done pulse. Every output is a
// register loaded from the next-state values, so nothing on the input side
// reaches an output combinationally.
module piso_tx_sequencer #(
  parameter int SIZE      = 4,
  parameter int BIT_TICKS = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  piso_tx_sequencer_if.slave  bus
);

  localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int BIT_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r,     state_s;
  logic [TICK_W-1:0] tick_cnt_r,  tick_cnt_s;
  logic [BIT_W-1:0]  bit_cnt_r,   bit_cnt_s;
  logic [SIZE-1:0]   piso_data_r, piso_data_s;

  logic piso_load_r,  piso_load_s;
  logic piso_en_r,    piso_en_s;
  logic busy_r,       busy_s;
  logic done_r,       done_s;
  logic data_ready_r, data_ready_s;

  // Next-state, counter and word-capture logic.
  always_comb begin
    state_s     = state_r;
    tick_cnt_s  = tick_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    piso_data_s = piso_data_r;
    case (state_r)
      ST_IDLE: begin
        // data_ready is high throughout IDLE, so valid alone completes the handshake.
        if (bus.data_valid) begin
          piso_data_s = bus.data_in;
          state_s     = ST_LOAD;
        end else begin
          state_s     = ST_IDLE;
        end
        tick_cnt_s = {TICK_W{1'b0}};
        bit_cnt_s  = {BIT_W{1'b0}};
      end
      ST_LOAD: begin
        tick_cnt_s = {TICK_W{1'b0}};
        bit_cnt_s  = {BIT_W{1'b0}};
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          state_s    = ST_IDLE;
          tick_cnt_s = {TICK_W{1'b0}};
          bit_cnt_s  = {BIT_W{1'b0}};
        end else if (tick_cnt_r == TICK_LAST) begin
          // Enable cycle: one bit leaves the shift register.
          tick_cnt_s = {TICK_W{1'b0}};
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_s = {BIT_W{1'b0}};
            state_s   = ST_DONE;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
            state_s   = ST_SHIFT;
          end
        end else begin
          tick_cnt_s = tick_cnt_r + TICK_W'(1);
          state_s    = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s    = ST_IDLE;
        tick_cnt_s = {TICK_W{1'b0}};
        bit_cnt_s  = {BIT_W{1'b0}};
      end
      default: begin
        state_s    = ST_IDLE;
        tick_cnt_s = {TICK_W{1'b0}};
        bit_cnt_s  = {BIT_W{1'b0}};
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state/counters.
  always_comb begin
    piso_load_s  = (state_s == ST_LOAD);
    piso_en_s    = (state_s == ST_SHIFT) && (tick_cnt_s == TICK_LAST);
    done_s       = (state_s == ST_DONE);
    busy_s       = (state_s != ST_IDLE);
    data_ready_s = (state_s == ST_IDLE);
  end

  // State, counter, captured word and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      tick_cnt_r   <= {TICK_W{1'b0}};
      bit_cnt_r    <= {BIT_W{1'b0}};
      piso_data_r  <= {SIZE{1'b0}};
      piso_load_r  <= 1'b0;
      piso_en_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      data_ready_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      tick_cnt_r   <= tick_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      piso_data_r  <= piso_data_s;
      piso_load_r  <= piso_load_s;
      piso_en_r    <= piso_en_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      data_ready_r <= data_ready_s;
    end
  end

  assign bus.piso_data  = piso_data_r;
  assign bus.piso_load  = piso_load_r;
  assign bus.piso_en    = piso_en_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.data_ready = data_ready_r;

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// Bench for piso_tx_sequencer: three configurations (4x3, 4x1, 8x5) driven
// with directed words, checked every cycle against a transaction-timeline
// model, plus hand-computed literal expectations for the key scenarios.
module tb_piso_tx_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  piso_tx_sequencer_if #(.SIZE(4)) if_a ();
  piso_tx_sequencer_if #(.SIZE(4)) if_b ();
  piso_tx_sequencer_if #(.SIZE(8)) if_c ();

  piso_tx_sequencer #(.SIZE(4), .BIT_TICKS(3)) u_a (.clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  piso_tx_sequencer #(.SIZE(4), .BIT_TICKS(1)) u_b (.clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  piso_tx_sequencer #(.SIZE(8), .BIT_TICKS(5)) u_c (.clk(clk), .reset_n(reset_n), .bus(if_c.slave));

  // Uniform views of the three DUTs.
  logic       v_valid[3], v_abort[3], v_ready[3], v_load[3], v_en[3], v_busy[3], v_done[3];
  logic [7:0] v_din[3], v_pdata[3];

  assign v_valid[0] = if_a.data_valid, v_abort[0] = if_a.abort, v_din[0] = {4'b0, if_a.data_in};
  assign v_valid[1] = if_b.data_valid, v_abort[1] = if_b.abort, v_din[1] = {4'b0, if_b.data_in};
  assign v_valid[2] = if_c.data_valid, v_abort[2] = if_c.abort, v_din[2] = if_c.data_in;
  assign v_ready[0] = if_a.data_ready, v_load[0] = if_a.piso_load, v_en[0] = if_a.piso_en;
  assign v_ready[1] = if_b.data_ready, v_load[1] = if_b.piso_load, v_en[1] = if_b.piso_en;
  assign v_ready[2] = if_c.data_ready, v_load[2] = if_c.piso_load, v_en[2] = if_c.piso_en;
  assign v_busy[0] = if_a.busy, v_done[0] = if_a.done, v_pdata[0] = {4'b0, if_a.piso_data};
  assign v_busy[1] = if_b.busy, v_done[1] = if_b.done, v_pdata[1] = {4'b0, if_b.piso_data};
  assign v_busy[2] = if_c.busy, v_done[2] = if_c.done, v_pdata[2] = if_c.piso_data;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transaction is the cycle window [L, L+SIZE*BIT_TICKS+1] after acceptance.
  int         m_sz[3] = '{4, 4, 8};
  int         m_bt[3] = '{3, 1, 5};
  bit         m_act[3] = '{1'b0, 1'b0, 1'b0};
  int         m_l[3] = '{0, 0, 0};
  logic [7:0] m_data[3] = '{8'h00, 8'h00, 8'h00};

  function automatic bit m_busy(input int i, input int c);
    return m_act[i] && (c >= m_l[i]) && (c <= m_l[i] + m_sz[i] * m_bt[i] + 1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i]  <= 1'b0;
        m_data[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_busy(i, cyc)) begin
          if (v_valid[i]) begin
            m_act[i]  <= 1'b1;
            m_l[i]    <= cyc + 1;
            m_data[i] <= v_din[i];
          end
        end else if (v_abort[i]) begin
          m_act[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int rel;
      bit b;
      rel = cyc - m_l[i];
      b = m_busy(i, cyc);
      check($sformatf("u%0d.data_ready", i), v_ready[i], !b);
      check($sformatf("u%0d.busy", i), v_busy[i], b);
      check($sformatf("u%0d.piso_load", i), v_load[i], b && rel == 0);
      check($sformatf("u%0d.piso_en", i), v_en[i],
            b && rel >= m_bt[i] && rel <= m_sz[i] * m_bt[i] && (rel % m_bt[i]) == 0);
      check($sformatf("u%0d.done", i), v_done[i], b && rel == m_sz[i] * m_bt[i] + 1);
      check($sformatf("u%0d.piso_data", i), v_pdata[i], m_data[i]);
    end
  end

  // Shift register attached to u_a, shifting MSB first.
  logic [3:0] sr_a;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr_a <= 4'h0;
    else if (v_load[0]) sr_a <= v_pdata[0][3:0];
    else if (v_en[0]) sr_a <= {sr_a[2:0], 1'b0};
  end

  task automatic drive(input int i, input logic vld, input logic ab, input logic [7:0] d);
    case (i)
      0: begin if_a.data_valid = vld; if_a.abort = ab; if_a.data_in = d[3:0]; end
      1: begin if_b.data_valid = vld; if_b.abort = ab; if_b.data_in = d[3:0]; end
      2: begin if_c.data_valid = vld; if_c.abort = ab; if_c.data_in = d; end
      default: ;
    endcase
  endtask

  // Present a word for one cycle; returns inside the LOAD cycle.
  task automatic send(input int i, input logic [7:0] d);
    @(posedge clk); #1 drive(i, 1'b1, 1'b0, d);
    @(posedge clk); #1 drive(i, 1'b0, 1'b0, 8'h00);
  endtask

  logic [63:0] en_h, done_h, ld_h, so_h, busy_h;
  int gap, cnt, sum, done_at;
  logic [7:0] pd;

  initial begin
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {v_ready[0], v_ready[1], v_ready[2]}, 3'b111);
    check("reset_busy", {v_busy[0], v_busy[1], v_busy[2]}, 3'b000);
    check("reset_pdata", {v_pdata[0], v_pdata[1], v_pdata[2]}, 24'h000000);
    @(negedge clk) reset_n = 1'b1;

    // 4x3, word 1011: load at 0, enables at 3,6,9,12, done at 13, bits 1,0,1,1 held 3 cycles.
    send(0, 8'h0B);
    en_h = '0; done_h = '0; ld_h = '0; so_h = '0;
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      en_h[r] = v_en[0]; done_h[r] = v_done[0]; ld_h[r] = v_load[0]; so_h[r] = sr_a[3];
    end
    check("t1_load", ld_h, 64'h1);
    check("t1_en", en_h, 64'h1248);
    check("t1_done", done_h, 64'h2000);
    check("t1_bits", {so_h[1], so_h[4], so_h[7], so_h[10]}, 4'b1011);
    check("t1_hold", so_h[12:1], 12'hFC7);

    // 4x1, word 0110: enables contiguous at 1..4, done at 5, busy 6 cycles.
    send(1, 8'h06);
    en_h = '0; done_h = '0; busy_h = '0;
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      en_h[r] = v_en[1]; done_h[r] = v_done[1]; busy_h[r] = v_busy[1];
    end
    check("t2_en", en_h, 64'h1E);
    check("t2_done", done_h, 64'h20);
    check("t2_busy", busy_h, 64'h3F);

    // Valid held across two words: second load lands 15 cycles after the first.
    repeat (2) @(posedge clk);
    #1 drive(0, 1'b1, 1'b0, 8'h0C);
    @(posedge clk); #1 drive(0, 1'b1, 1'b0, 8'h05);
    gap = 0; pd = 8'h00;
    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      if (r > 0 && v_load[0]) begin gap = r; pd = v_pdata[0]; break; end
    end
    #1 drive(0, 1'b0, 1'b0, 8'h00);
    check("t3_gap", gap, 15);
    check("t3_word2", pd, 8'h05);
    repeat (16) @(posedge clk);

    // Abort one cycle after the second enable; then abort together with valid in IDLE.
    send(0, 8'h09);
    repeat (7) @(negedge clk);
    @(posedge clk); #1 drive(0, 1'b0, 1'b1, 8'h00);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("t4_idle", {v_busy[0], v_ready[0]}, 2'b01);
    cnt = 0;
    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      cnt += int'(v_en[0]) + int'(v_done[0]);
    end
    check("t4_quiet", cnt, 0);
    @(posedge clk); #1 drive(0, 1'b1, 1'b1, 8'h03);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("t4_accept", {v_load[0], v_pdata[0]}, 9'h103);
    repeat (16) @(posedge clk);

    // Asynchronous reset in the middle of SHIFT, then a normal transfer.
    send(0, 8'h0A);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_outs", {v_en[0], v_load[0], v_done[0], v_busy[0], v_ready[0]}, 5'b00001);
    check("t5_pdata", v_pdata[0], 8'h00);
    @(negedge clk) reset_n = 1'b1;
    send(0, 8'h06);
    en_h = '0; done_h = '0;
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      en_h[r] = v_en[0]; done_h[r] = v_done[0];
    end
    check("t5_en", en_h, 64'h1248);
    check("t5_done", done_h, 64'h2000);

    // 8x5, word A5: 8 enables at 5,10,..,40 (sum 180), done at 41.
    send(2, 8'hA5);
    cnt = 0; sum = 0; done_at = -1;
    for (int r = 0; r < 43; r++) begin
      @(negedge clk);
      if (v_en[2]) begin cnt++; sum += r; end
      if (v_done[2]) done_at = r;
    end
    check("t6_en_count", cnt, 8);
    check("t6_en_sum", sum, 180);
    check("t6_done", done_at, 41);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
